// File: rtl/lab5_divider_toplevel.sv
`default_nettype none
// ============================================================================
//  Module   : lab5_divider_toplevel
//  Purpose  : Sequential 8-bit unsigned restoring divider. A:B / SW leaves
//             the remainder in A and the quotient in B, with seven-segment
//             decodes of both registers.
//  Revision : 1.0  initial release
// ============================================================================
module lab5_divider_toplevel (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] SW,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic       LoadA,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       Xval,
    output logic       Busy,
    output logic [6:0] AhexU,
    output logic [6:0] AhexL,
    output logic [6:0] BhexU,
    output logic [6:0] BhexL
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_DIV   = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_a;
    logic [7:0] w_a_next;
    logic [7:0] r_b;
    logic [7:0] w_b_next;
    logic [7:0] r_d;
    logic [7:0] w_d_next;
    logic       r_x;
    logic       w_x_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;

    // 9-bit partial remainder keeps the bit shifted out of A in the compare.
    logic [8:0] w_t;
    logic       w_ge;
    logic [7:0] w_rem;
    logic       w_err;

    assign w_t   = {r_a, r_b[7]};
    assign w_ge  = (w_t >= {1'b0, r_d});
    assign w_rem = w_t[7:0] - r_d;
    // A >= D means the quotient would not fit in 8 bits.
    assign w_err = (r_d == 8'd0) || (r_a >= r_d);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_IDLE;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_d     <= 8'd0;
            r_x     <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_d     <= w_d_next;
            r_x     <= w_x_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_d_next     = r_d;
        w_x_next     = r_x;
        w_cnt_next   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (!Run) begin
                    w_d_next     = SW;
                    w_state_next = c_CHECK;
                end else if (!ClearA_LoadB && !LoadA) begin
                    w_a_next = SW;
                    w_b_next = SW;
                    w_x_next = 1'b0;
                end else if (!ClearA_LoadB) begin
                    w_a_next = 8'd0;
                    w_b_next = SW;
                    w_x_next = 1'b0;
                end else if (!LoadA) begin
                    w_a_next = SW;
                    w_x_next = 1'b0;
                end
            end
            c_CHECK: begin
                if (w_err) begin
                    w_x_next     = 1'b1;
                    w_state_next = c_HOLD;
                end else begin
                    w_x_next     = 1'b0;
                    w_cnt_next   = 3'd0;
                    w_state_next = c_DIV;
                end
            end
            c_DIV: begin
                if (w_ge) begin
                    w_a_next = w_rem;
                    w_b_next = {r_b[6:0], 1'b1};
                end else begin
                    w_a_next = w_t[7:0];
                    w_b_next = {r_b[6:0], 1'b0};
                end
                w_cnt_next = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_next = c_HOLD;
                end
            end
            c_HOLD: begin
                if (Run) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    function automatic logic [6:0] f_hex7(input logic [3:0] v);
        logic [6:0] seg;
        seg = 7'b1111111;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign Aval  = r_a;
    assign Bval  = r_b;
    assign Xval  = r_x;
    assign Busy  = (r_state == c_CHECK) || (r_state == c_DIV);
    assign AhexU = f_hex7(r_a[7:4]);
    assign AhexL = f_hex7(r_a[3:0]);
    assign BhexU = f_hex7(r_b[7:4]);
    assign BhexL = f_hex7(r_b[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_lab5_divider_toplevel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab5_divider_toplevel
//  Purpose  : Directed self-checking bench for lab5_divider_toplevel with a
//             scoreboard of expected division results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lab5_divider_toplevel;

    logic       Clk;
    logic       Reset;
    logic [7:0] SW;
    logic       Run;
    logic       ClearA_LoadB;
    logic       LoadA;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Busy;
    logic [6:0] AhexU;
    logic [6:0] AhexL;
    logic [6:0] BhexU;
    logic [6:0] BhexL;

    lab5_divider_toplevel dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .SW           (SW),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .LoadA        (LoadA),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Busy         (Busy),
        .AhexU        (AhexU),
        .AhexL        (AhexL),
        .BhexU        (BhexU),
        .BhexL        (BhexL)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
        logic [7:0] busy;
    } exp_t;

    exp_t       r_sb[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic       m_x = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic chk_hex(input string tag);
        chk({tag, "_AhexU"}, {9'd0, AhexU}, {9'd0, seg_of(m_a[7:4])});
        chk({tag, "_AhexL"}, {9'd0, AhexL}, {9'd0, seg_of(m_a[3:0])});
        chk({tag, "_BhexU"}, {9'd0, BhexU}, {9'd0, seg_of(m_b[7:4])});
        chk({tag, "_BhexL"}, {9'd0, BhexL}, {9'd0, seg_of(m_b[3:0])});
    endtask

    task automatic press_clear(input logic [7:0] sw);
        @(negedge Clk);
        SW = sw; ClearA_LoadB = 1'b0;
        @(negedge Clk);
        ClearA_LoadB = 1'b1;
        m_a = 8'd0; m_b = sw; m_x = 1'b0;
    endtask

    task automatic press_loada(input logic [7:0] sw);
        @(negedge Clk);
        SW = sw; LoadA = 1'b0;
        @(negedge Clk);
        LoadA = 1'b1;
        m_a = sw; m_x = 1'b0;
    endtask

    task automatic press_both(input logic [7:0] sw);
        @(negedge Clk);
        SW = sw; LoadA = 1'b0; ClearA_LoadB = 1'b0;
        @(negedge Clk);
        LoadA = 1'b1; ClearA_LoadB = 1'b1;
        m_a = sw; m_b = sw; m_x = 1'b0;
    endtask

    // Runs one division: Run held low for 'hold' samples, ClearA_LoadB pulsed
    // at sample 'pulse_at' (negative for none).
    task automatic do_div(input string tag, input logic [7:0] dv, input int hold, input int pulse_at);
        exp_t    e;
        exp_t    got;
        int      busy_n;
        bit      seen;
        bit      done;
        logic [15:0] dividend;
        busy_n = 0; seen = 1'b0; done = 1'b0;
        dividend = {m_a, m_b};
        if (dv == 8'd0 || m_a >= dv) begin
            e = '{a: m_a, b: m_b, x: 1'b1, busy: 8'd1};
        end else begin
            e.a = 8'(dividend % {8'd0, dv});
            e.b = 8'(dividend / {8'd0, dv});
            e.x = 1'b0;
            e.busy = 8'd9;
        end
        r_sb.push_back(e);
        m_a = e.a; m_b = e.b; m_x = e.x;
        @(negedge Clk);
        SW = dv; Run = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge Clk);
            if (k == hold) Run = 1'b1;
            ClearA_LoadB = (k == pulse_at) ? 1'b0 : 1'b1;
            if (Busy) begin
                busy_n++;
                seen = 1'b1;
            end else if (seen && k >= hold) begin
                done = 1'b1;
                break;
            end
        end
        Run = 1'b1; ClearA_LoadB = 1'b1;
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        got = r_sb.pop_front();
        chk({tag, "_busy"}, 16'(busy_n), {8'd0, got.busy});
        chk({tag, "_A"}, {8'd0, Aval}, {8'd0, got.a});
        chk({tag, "_B"}, {8'd0, Bval}, {8'd0, got.b});
        chk({tag, "_X"}, {15'd0, Xval}, {15'd0, got.x});
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0; SW = 8'd0; Run = 1'b1; ClearA_LoadB = 1'b1; LoadA = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_A", {8'd0, Aval}, 16'd0);
        chk("rst_B", {8'd0, Bval}, 16'd0);
        chk("rst_X", {15'd0, Xval}, 16'd0);
        chk("rst_Busy", {15'd0, Busy}, 16'd0);
        chk_hex("rst");
        Reset = 1'b1;

        // 100 / 7
        press_clear(8'h64);
        do_div("basic", 8'h07, 5, -1);
        chk("basic_A_lit", {8'd0, Aval}, 16'h0002);
        chk("basic_B_lit", {8'd0, Bval}, 16'h000E);
        chk_hex("basic");

        // 1023 / 16
        press_clear(8'hFF);
        press_loada(8'h03);
        do_div("wide", 8'h10, 12, -1);
        chk("wide_B_lit", {8'd0, Bval}, 16'h003F);
        chk("wide_A_lit", {8'd0, Aval}, 16'h000F);

        // 0xFEFF / 0xFF needs the 9-bit partial remainder
        press_clear(8'hFF);
        press_loada(8'hFE);
        do_div("carry", 8'hFF, 12, -1);
        chk("carry_B_lit", {8'd0, Bval}, 16'h00FF);
        chk("carry_A_lit", {8'd0, Aval}, 16'h00FE);
        chk_hex("carry");

        // Overflow then divide by zero
        press_clear(8'h00);
        press_loada(8'h05);
        do_div("ovf", 8'h05, 5, -1);
        do_div("dz", 8'h00, 5, -1);
        chk("dz_A_lit", {8'd0, Aval}, 16'h0005);
        press_clear(8'h64);
        chk("clr_X", {15'd0, Xval}, 16'd0);
        chk("clr_B", {8'd0, Bval}, 16'h0064);

        // Run held 40 cycles with a button pulse mid-division, then chain
        do_div("hold", 8'h07, 40, 4);
        chk("hold_B_lit", {8'd0, Bval}, 16'h000E);
        do_div("chain", 8'h05, 12, -1);
        chk("chain_A_lit", {8'd0, Aval}, 16'h0001);
        chk("chain_B_lit", {8'd0, Bval}, 16'h0069);

        // Both load buttons together
        press_both(8'h03);
        chk("both_A", {8'd0, Aval}, 16'h0003);
        chk("both_B", {8'd0, Bval}, 16'h0003);
        do_div("both", 8'h05, 12, -1);

        // Reset while the iteration counter reads 3
        press_clear(8'hC8);
        @(negedge Clk);
        SW = 8'h07; Run = 1'b0;
        repeat (5) @(negedge Clk);
        chk("mid_busy_pre", {15'd0, Busy}, 16'd1);
        #2 Reset = 1'b0;
        #1;
        m_a = 8'd0; m_b = 8'd0; m_x = 1'b0;
        chk("mid_A", {8'd0, Aval}, 16'd0);
        chk("mid_B", {8'd0, Bval}, 16'd0);
        chk("mid_X", {15'd0, Xval}, 16'd0);
        chk("mid_Busy", {15'd0, Busy}, 16'd0);
        chk_hex("mid");
        Run = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        press_clear(8'h64);
        do_div("post", 8'h07, 5, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab5_divider_toplevel.md
# lab5_divider_toplevel

Sequential 8-bit unsigned restoring divider: the inverse of the lab5 shift-add multiplier, driven from the same board controls (8 switches, active-low Run/ClearA_LoadB/LoadA buttons, four hex displays). Divides the 16-bit dividend held in A:B by an 8-bit divisor taken from the switches. Leaves the 8-bit remainder in A and the 8-bit quotient in B. A product left by a multiply can be loaded back as A:B and divided to recover an operand.

## Interface
- No parameters; all datapaths are fixed at 8 bits.
- Clk  in  1  system clock, 50 MHz; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- SW  in  8  switch operand: load data in IDLE, divisor sampled at Run start
- Run  in  1  active-low start; level-sensitive, synchronous to Clk (debounced/synchronized upstream)
- ClearA_LoadB  in  1  active-low; in IDLE: A<=0, B<=SW, Xval<=0
- LoadA  in  1  active-low; in IDLE: A<=SW, Xval<=0
- Aval  out  8  A register (dividend high byte / remainder)
- Bval  out  8  B register (dividend low byte / quotient)
- Xval  out  1  error flag: divide-by-zero or quotient overflow
- Busy  out  1  high while in CHECK or DIV
- AhexU, AhexL, BhexU, BhexL  out  7 each  active-low seven-segment decodes of Aval[7:4], Aval[3:0], Bval[7:4], Bval[3:0]; segment order {g,f,e,d,c,b,a}; hex digits 0-F

## Operation
- Registers: A[7:0], B[7:0], D[7:0] (divisor), Xval, 3-bit iteration counter, state.
- States: IDLE, CHECK, DIV, HOLD.
- IDLE
  - Load controls act only here.
  - ClearA_LoadB low and LoadA low in the same cycle: A<=SW, B<=SW, Xval<=0.
  - Run low: D<=SW, go to CHECK. Run has priority; load buttons are ignored that cycle.
- CHECK (1 cycle)
  - If D==0 or A>=D: Xval<=1, A and B unchanged, go to HOLD.
  - Else: Xval<=0, counter<=0, go to DIV.
- DIV (8 cycles, counter 0..7), one iteration per cycle:
  - Form the 9-bit value T = {A,B[7]} (A shifted left, B's MSB shifted in).
  - If T >= {0,D}: A <= (T - D)[7:0] and B <= {B[6:0],1}.
  - Else: A <= T[7:0] and B <= {B[6:0],0}.
  - T is compared in 9 bits, so the A MSB carry-out is never lost.
  - At counter==7, go to HOLD.
- HOLD: registers frozen; return to IDLE when Run is high. One Run press yields exactly one division regardless of hold length.
- Load buttons in CHECK/DIV/HOLD are ignored. Run transitions during DIV are ignored.
- The hex outputs are a purely combinational decode of the registers, updated the same cycle the registers change.

## Timing
- Reset asserted (any time, including mid-DIV):
  - Immediately: A=0, B=0, D=0, Xval=0, Busy=0, counter=0, state=IDLE.
  - All hex outputs = 7'b1000000 ('0').
- On reset deassertion, the first active edge is evaluated in IDLE.
- Latency, edge E0 = Run sampled low in IDLE:
  - E1: CHECK executes; Busy is high during the cycle after E0.
  - E2..E9: DIV iterations.
  - After E9: result valid, Busy low, state HOLD.
  - Total: 9 cycles after the start edge.
- Error path: Xval rises after E1. Busy is high for exactly one cycle.
- Busy = (state==CHECK || state==DIV), registered-state decode with no glitch path from inputs.
- Run held low through completion: stays in HOLD. Run high at the edge after the result: IDLE next cycle. Run low again: a new division starts the following sample.
- Chained divides: the remainder stays in A. A new ClearA_LoadB zeroes A before the next operand.

## Test plan
- Basic:
  - Stimulus: Reset pulse; ClearA_LoadB with SW=0x64; SW=0x07; Run low 5 cycles.
  - Required: A=0x02, B=0x0E, Xval=0.
  - Required: Busy high exactly 9 cycles, then HOLD.
- 16-bit dividend:
  - Stimulus: ClearA_LoadB SW=0xFF; LoadA SW=0x03; Run with SW=0x10 (1023/16).
  - Required: B=0x3F, A=0x0F.
- Max/carry:
  - Stimulus: A=0xFE, B=0xFF, D=0xFF.
  - Required: B=0xFF, A=0xFE. Exercises the 9-bit compare.
- Errors:
  - Stimulus: A=0x05, B=0x00 with D=0x05; then D=0x00.
  - Required: Xval=1 after 1 Busy cycle; A/B unchanged.
  - Required: a following ClearA_LoadB clears Xval.
- Run/buttons:
  - Stimulus: Run held low 40 cycles; ClearA_LoadB pulsed during DIV.
  - Required: only one division; registers unaffected by the button.
  - Stimulus: release Run, press again.
  - Required: second division on the remainder/quotient left in A:B.
- Reset mid-op:
  - Stimulus: assert Reset at DIV counter==3, asynchronous to the clock edge.
  - Required: A=B=0, Xval=0, Busy=0 immediately; all hex = 7'b1000000.
